// File: rtl/demux_1ton_buf.sv
// Registered 1-to-N valid/ready demultiplexer with a one-entry holding register per channel.
// Optional broadcast input enabled by defining DEMUX_1TON_BCAST_EN.
module demux_1ton_buf #(
  parameter  int N     = 8,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [W-1:0]     i_data,
  input  logic [SEL_W-1:0] s,
  input  logic             rr_mode,
`ifdef DEMUX_1TON_BCAST_EN
  input  logic             bcast,
`endif
  output logic [N-1:0]     y_valid,
  input  logic [N-1:0]     y_ready,
  output logic [N*W-1:0]   y_data,
  output logic             err
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [N-1:0]     r_valid;
  logic [N*W-1:0]   r_data;
  logic [SEL_W-1:0] r_ptr;
  logic             r_err;

  logic [SEL_W-1:0] w_tgt;
  logic             w_in_rng;
  logic [N-1:0]     w_free;
  logic [N-1:0]     w_load;
  logic             w_acc;
  logic             w_drop;
  logic             w_adv;
  logic             w_bc;

`ifdef DEMUX_1TON_BCAST_EN
  assign w_bc = bcast;
`else
  assign w_bc = 1'b0;
`endif

  // Out-of-range targets are always ready so the word is swallowed.
  always_comb begin
    w_tgt    = rr_mode ? r_ptr : s;
    w_in_rng = {1'b0, w_tgt} < N_EXT;
    w_free   = ~r_valid | y_ready;
    i_ready  = w_in_rng ? w_free[w_tgt] : 1'b1;
    if (w_bc)
      i_ready = &w_free;
    w_acc  = i_valid & i_ready;
    w_load = '0;
    for (int k = 0; k < N; k++) begin
      if (w_bc || (w_in_rng && w_tgt == SEL_W'(k)))
        w_load[k] = w_acc;
    end
    w_drop = w_acc & ~w_bc & ~w_in_rng;
    w_adv  = w_acc & ~w_bc & rr_mode;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_drop;
      for (int k = 0; k < N; k++) begin
        if (w_load[k]) begin
          r_valid[k]       <= 1'b1;
          r_data[k*W +: W] <= i_data;
        end else if (y_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_adv)
        r_ptr <= (r_ptr == SEL_W'(N-1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign y_valid = r_valid;
  assign y_data  = r_data;
  assign err     = r_err;

endmodule
